axi_lite_write_arb: RTL and testbench

AXI_LITE_WRITE_ARB -- requirements
Module: axi_lite_write_arb

---
 rtl/axi_lite_write_arb.sv | 80 ++++++++
 tb/tb_axi_lite_write_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_write_arb.sv
// axi_lite_write_arb: round-robin arbiter sharing one AXI4-Lite write slave between two requesters
module axi_lite_write_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARSTn,
  input  logic [2*ADDR_W-1:0] S_AWADDR,
  input  logic [1:0]          S_AWVALID,
  output logic [1:0]          S_AWREADY,
  input  logic [2*DATA_W-1:0] S_WDATA,
  input  logic [1:0]          S_WVALID,
  output logic [1:0]          S_WREADY,
  output logic [1:0]          S_BVALID,
  input  logic [1:0]          S_BREADY,
  output logic [3:0]          S_BRESP,
  output logic [ADDR_W-1:0]   M_AWADDR,
  output logic                M_AWVALID,
  input  logic                M_AWREADY,
  output logic [DATA_W-1:0]   M_WDATA,
  output logic                M_WVALID,
  input  logic                M_WREADY,
  input  logic                M_BVALID,
  output logic                M_BREADY,
  input  logic [1:0]          M_BRESP,
  output logic [1:0]          GRANT
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d, last_q, last_d, pick;
  logic       g, in_a, in_d, in_r;
  assign g = grant_q[1];
  // on a tie the requester that did not win last time goes first
  assign pick = (&S_AWVALID) ? (last_q[0] ? 2'b10 : 2'b01) : S_AWVALID;
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 2'b10;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (|S_AWVALID) begin
        state_d = ADDR;
        grant_d = pick;
      end
      ADDR: if (M_AWVALID && M_AWREADY) state_d = DATA;
      DATA: if (M_WVALID && M_WREADY) state_d = RESP;
      RESP: if (M_BVALID && M_BREADY) begin
        state_d = IDLE;
        grant_d = 2'b00;
        last_d  = grant_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_a      = state_q == ADDR;
    in_d      = state_q == DATA;
    in_r      = state_q == RESP;
    M_AWADDR  = in_a ? (g ? S_AWADDR[2*ADDR_W-1:ADDR_W] : S_AWADDR[ADDR_W-1:0]) : '0;
    M_AWVALID = in_a && S_AWVALID[g];
    M_WDATA   = in_d ? (g ? S_WDATA[2*DATA_W-1:DATA_W] : S_WDATA[DATA_W-1:0]) : '0;
    M_WVALID  = in_d && S_WVALID[g];
    M_BREADY  = in_r && S_BREADY[g];
    S_AWREADY = in_a ? grant_q & {2{M_AWREADY}} : 2'b00;
    S_WREADY  = in_d ? grant_q & {2{M_WREADY}} : 2'b00;
    S_BVALID  = in_r ? grant_q & {2{M_BVALID}} : 2'b00;
    S_BRESP   = in_r ? (g ? {M_BRESP, 2'b00} : {2'b00, M_BRESP}) : 4'b0000;
    GRANT     = grant_q;
  end
endmodule

// File: tb/tb_axi_lite_write_arb.sv
// tb_axi_lite_write_arb: directed bench with a simple slave and two requester models
module tb_axi_lite_write_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  logic          ACLK = 1'b0;
  logic          ARSTn = 1'b0;
  logic [2*AW-1:0] S_AWADDR;
  logic [1:0]    S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
  logic [2*DW-1:0] S_WDATA;
  logic [3:0]    S_BRESP;
  logic [AW-1:0] M_AWADDR;
  logic [DW-1:0] M_WDATA;
  logic          M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic [1:0]    M_BRESP, GRANT;
  logic [1:0]    aw_p, w_p;
  logic [AW-1:0] a_reg [2];
  logic [DW-1:0] d_reg [2];
  bit            auto_rq;
  int            n_checks, n_errors, cyc, done_cnt, d0;
  logic [AW-1:0] addr_log [$];
  logic [1:0]    gnt_log [$];
  logic [3:0]    resp_log [$];
  int            cyc_log [$];
  assign S_AWADDR  = {a_reg[1], a_reg[0]};
  assign S_WDATA   = {d_reg[1], d_reg[0]};
  assign S_AWVALID = aw_p;
  assign S_WVALID  = w_p;
  axi_lite_write_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARSTn(ARSTn),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BRESP(S_BRESP),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BRESP(M_BRESP),
    .GRANT(GRANT)
  );
  always #5 ACLK = ~ACLK;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic req(int i, logic [AW-1:0] a, logic [DW-1:0] d);
    a_reg[i] = a;
    d_reg[i] = d;
    aw_p[i]  = 1'b1;
    w_p[i]   = 1'b1;
  endtask
  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask
  task automatic wait_idle(string tag);
    int k = 0;
    while (!(aw_p == 2'b00 && w_p == 2'b00 && GRANT == 2'b00 && !M_BVALID) && k < 200) begin
      tick();
      k++;
    end
    check(tag, 64'(k < 200), 64'd1);
  endtask
  task automatic do_reset();
    ARSTn = 1'b0;
    aw_p  = 2'b00;
    w_p   = 2'b00;
    repeat (2) @(posedge ACLK);
    #2;
    ARSTn = 1'b1;
    addr_log.delete();
    gnt_log.delete();
    resp_log.delete();
    cyc_log.delete();
  endtask
  // slave pulses AWREADY/WREADY one cycle after valid and returns B the cycle after W;
  // requesters drop each valid on its own handshake
  initial begin
    logic aw_hs, w_hs, b_hs;
    logic [1:0] saw, sw, sb;
    M_AWREADY = 1'b0;
    M_WREADY  = 1'b0;
    M_BVALID  = 1'b0;
    forever begin
      @(negedge ACLK);
      aw_hs = M_AWVALID && M_AWREADY;
      w_hs  = M_WVALID && M_WREADY;
      b_hs  = M_BVALID && M_BREADY;
      saw   = S_AWVALID & S_AWREADY;
      sw    = S_WVALID & S_WREADY;
      sb    = S_BVALID & S_BREADY;
      if (aw_hs) begin
        addr_log.push_back(M_AWADDR);
        gnt_log.push_back(GRANT);
        cyc_log.push_back(cyc);
      end
      if (|sb) begin
        done_cnt++;
        resp_log.push_back(S_BRESP);
      end
      @(posedge ACLK);
      #1;
      cyc++;
      aw_p = aw_p & ~saw;
      w_p  = w_p & ~sw;
      if (auto_rq) begin
        aw_p = aw_p | sb;
        w_p  = w_p | sb;
      end
      M_AWREADY = M_AWVALID && !M_AWREADY;
      M_WREADY  = M_WVALID && !M_WREADY;
      M_BVALID  = ARSTn && (w_hs || (M_BVALID && !b_hs));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int k;
    aw_p = 2'b00;
    w_p = 2'b00;
    a_reg[0] = '0; a_reg[1] = '0;
    d_reg[0] = '0; d_reg[1] = '0;
    S_BREADY = 2'b11;
    M_BRESP = 2'b00;
    auto_rq = 1'b0;
    #3;
    check("rst_grant", GRANT, 2'b00);
    check("rst_m_valids", {M_AWVALID, M_WVALID, M_BREADY}, 3'b000);
    check("rst_s_outs", {S_AWREADY, S_WREADY, S_BVALID, S_BRESP}, 10'd0);
    check("rst_m_addr_data", {M_AWADDR, M_WDATA}, 64'd0);
    repeat (2) @(posedge ACLK);
    #2;
    ARSTn = 1'b1;
    tick();
    // single write from requester 0
    req(0, 32'h10, 32'h1111_2222);
    @(negedge ACLK);
    check("t1_arb_awvalid", M_AWVALID, 1'b0);
    check("t1_arb_grant", GRANT, 2'b00);
    @(negedge ACLK);
    check("t1_a_grant", GRANT, 2'b01);
    check("t1_a_awvalid", M_AWVALID, 1'b1);
    check("t1_a_awaddr", M_AWADDR, 32'h10);
    check("t1_a_awready", S_AWREADY, 2'b01);
    @(negedge ACLK);
    check("t1_d_grant", GRANT, 2'b01);
    check("t1_d_awvalid", M_AWVALID, 1'b0);
    check("t1_d_wdata", M_WDATA, 32'h1111_2222);
    check("t1_d_wready", S_WREADY, 2'b01);
    @(negedge ACLK);
    check("t1_r_grant", GRANT, 2'b01);
    check("t1_r_bvalid", S_BVALID, 2'b01);
    check("t1_r_bresp", S_BRESP, 4'b0000);
    check("t1_r_bready", M_BREADY, 1'b1);
    @(negedge ACLK);
    check("t1_idle_grant", GRANT, 2'b00);
    check("t1_done", done_cnt, 1);
    // simultaneous request straight after reset
    do_reset();
    M_BRESP = 2'b10;
    req(0, 32'h20, 32'hA0);
    req(1, 32'h24, 32'hA1);
    wait_idle("t2_timeout");
    check("t2_count", addr_log.size(), 2);
    check("t2_addr0", addr_log[0], 32'h20);
    check("t2_addr1", addr_log[1], 32'h24);
    check("t2_gnt0", gnt_log[0], 2'b01);
    check("t2_gnt1", gnt_log[1], 2'b10);
    check("t2_b2b_gap", cyc_log[1] - cyc_log[0], 4);
    check("t2_resp0", resp_log[0], 4'b0010);
    check("t2_resp1", resp_log[1], 4'b1000);
    // fairness under continuous requests
    gnt_log.delete();
    M_BRESP = 2'b00;
    auto_rq = 1'b1;
    req(0, 32'h30, 32'hB0);
    req(1, 32'h34, 32'hB1);
    k = 0;
    while (gnt_log.size() < 4 && k < 200) begin
      tick();
      k++;
    end
    check("t3_timeout", 64'(k < 200), 64'd1);
    auto_rq = 1'b0;
    wait_idle("t3_drain");
    check("t3_gnt0", gnt_log[0], 2'b01);
    check("t3_gnt1", gnt_log[1], 2'b10);
    check("t3_gnt2", gnt_log[2], 2'b01);
    check("t3_gnt3", gnt_log[3], 2'b10);
    // late request does not preempt
    gnt_log.delete();
    addr_log.delete();
    req(0, 32'h50, 32'hC0);
    @(negedge ACLK);
    @(negedge ACLK);
    tick();
    req(1, 32'h54, 32'hC1);
    @(negedge ACLK);
    check("t4_d_grant", GRANT, 2'b01);
    check("t4_d_awready", S_AWREADY, 2'b00);
    @(negedge ACLK);
    check("t4_r_grant", GRANT, 2'b01);
    wait_idle("t4_timeout");
    check("t4_gnt0", gnt_log[0], 2'b01);
    check("t4_gnt1", gnt_log[1], 2'b10);
    check("t4_addr1", addr_log[1], 32'h54);
    // B backpressure for five cycles
    S_BREADY = 2'b10;
    req(0, 32'h58, 32'hD0);
    k = 0;
    @(negedge ACLK);
    while (!S_BVALID[0] && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    check("t5_bvalid_seen", 64'(k < 20), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_bready", M_BREADY, 1'b0);
      check("t5_hold_grant", GRANT, 2'b01);
      if (i < 4) @(negedge ACLK);
    end
    tick();
    S_BREADY = 2'b11;
    @(negedge ACLK);
    check("t5_bready_up", M_BREADY, 1'b1);
    check("t5_still_granted", GRANT, 2'b01);
    @(posedge ACLK);
    #1;
    check("t5_complete", GRANT, 2'b00);
    wait_idle("t5_timeout");
    // reset asserted during DATA
    req(0, 32'h60, 32'h66);
    @(negedge ACLK);
    @(negedge ACLK);
    @(negedge ACLK);
    check("t6_in_data", M_WVALID, 1'b1);
    d0 = done_cnt;
    #1;
    ARSTn = 1'b0;
    #1;
    check("t6_grant", GRANT, 2'b00);
    check("t6_m_outs", {M_AWVALID, M_WVALID, M_BREADY}, 3'b000);
    check("t6_s_outs", {S_AWREADY, S_WREADY, S_BVALID}, 6'b000000);
    check("t6_wdata", M_WDATA, 32'h0);
    do_reset();
    check("t6_no_resp", done_cnt, d0);
    req(1, 32'h70, 32'h77);
    wait_idle("t6_timeout");
    check("t6_next_addr", addr_log[addr_log.size()-1], 32'h70);
    check("t6_next_gnt", gnt_log[gnt_log.size()-1], 2'b10);
    check("t6_next_done", done_cnt, d0 + 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
